// File: rtl/nios2_qsys_oci_dct_pkg.sv
// Shared sizing and FSM encoding for the OCI data-trace packer.
package nios2_qsys_oci_dct_pkg;
  localparam int CODE_W  = 3;
  localparam int SLOTS   = 10;
  localparam int FRAME_W = CODE_W * SLOTS;
  localparam int CNT_W   = 4;

  localparam logic [CNT_W-1:0] SLOTS_CNT = CNT_W'(SLOTS);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    WAIT  = 2'd2,
    ENDED = 2'd3
  } dct_state_e;
endpackage

// File: rtl/nios2_qsys_oci_dct_packer_if.sv
// Frame hand-off bus from the packer to the trace FIFO (valid/ready).
interface nios2_qsys_oci_dct_packer_if;
  import nios2_qsys_oci_dct_pkg::*;

  logic               frame_valid;
  logic               frame_ready;
  logic [FRAME_W-1:0] frame_data;
  logic [CNT_W-1:0]   frame_count;

  modport master (output frame_valid, frame_data, frame_count, input frame_ready);
  modport slave  (input frame_valid, frame_data, frame_count, output frame_ready);
endinterface

// File: rtl/nios2_qsys_oci_dct_frame_reg.sv
// Single-entry output frame register; flags a stall when a load meets a full,
// unaccepted slot and keeps the sticky overflow flag.
module nios2_qsys_oci_dct_frame_reg
  import nios2_qsys_oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] data_i,
  input  logic [CNT_W-1:0]   count_i,
  input  logic               drop_i,
  input  logic               ovf_clr_i,
  output logic               can_load_o,
  output logic               overflow_o,
  nios2_qsys_oci_dct_packer_if.master fo
);
  logic               fv_q, fv_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               stall;

  assign can_load_o = !fv_q || fo.frame_ready;
  assign stall      = load_i && !can_load_o;

  always_comb begin
    fv_d   = fv_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i && can_load_o) begin
      fv_d   = 1'b1;
      data_d = data_i;
      cnt_d  = count_i;
    end else if (fv_q && fo.frame_ready) begin
      fv_d = 1'b0;
    end
    // Setting wins over a simultaneous clear.
    if (stall || drop_i)  ovf_d = 1'b1;
    else if (ovf_clr_i)   ovf_d = 1'b0;
    else                  ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fv_q   <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      fv_q   <= fv_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign fo.frame_valid = fv_q;
  assign fo.frame_data  = data_q;
  assign fo.frame_count = cnt_q;
  assign overflow_o     = ovf_q;
endmodule

// File: rtl/nios2_qsys_oci_dct_packer.sv
// Packs 3-bit DCT codes into 30-bit frames and sequences the end-of-test
// drain that the simulation monitor waits on.
module nios2_qsys_oci_dct_packer
  import nios2_qsys_oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               trc_on,
  input  logic               code_valid,
  input  logic [CODE_W-1:0]  code,
  input  logic               flush,
  input  logic               end_req,
  input  logic               overflow_clr,
  nios2_qsys_oci_dct_packer_if.master frame_if,
  output logic [FRAME_W-1:0] dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               overflow,
  output logic               test_ending,
  output logic               test_has_ended
);
  dct_state_e         state_q, state_d;
  logic [FRAME_W-1:0] buf_q, buf_d, nb, em_buf;
  logic [CNT_W-1:0]   cnt_q, cnt_d, nc, em_cnt;
  logic               flush_q, flush_d;
  logic               te_q, te_d;
  logic               acc_ok, drop_st, flush_pend, drain, emit, can_load;

  assign acc_ok     = code_valid && trc_on && (state_q == RUN);
  assign drop_st    = code_valid && trc_on && (state_q != RUN);
  assign flush_pend = flush || flush_q;
  assign drain      = (state_q == DRAIN);
  assign nb         = {buf_q[FRAME_W-CODE_W-1:0], code};
  assign nc         = cnt_q + CNT_W'(1);

  // Packer next state; a stalled emit freezes the packer and keeps any flush.
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    emit    = 1'b0;
    em_buf  = buf_q;
    em_cnt  = cnt_q;
    if (cnt_q == SLOTS_CNT) begin
      emit = 1'b1;
      if (can_load) begin
        buf_d = acc_ok ? {{(FRAME_W-CODE_W){1'b0}}, code} : '0;
        cnt_d = acc_ok ? CNT_W'(1) : '0;
      end else begin
        flush_d = flush_pend;
      end
    end else if (acc_ok) begin
      emit   = (nc == SLOTS_CNT) || flush_pend;
      em_buf = nb;
      em_cnt = nc;
      if (!emit) begin
        buf_d = nb;
        cnt_d = nc;
      end else if (can_load) begin
        buf_d = '0;
        cnt_d = '0;
      end else begin
        // The code that completes a frame is kept; it then waits as a full packer.
        if (nc == SLOTS_CNT) begin
          buf_d = nb;
          cnt_d = nc;
        end
        flush_d = flush_pend;
      end
    end else begin
      emit = (flush_pend || drain) && (cnt_q != '0);
      if (emit && can_load) begin
        buf_d = '0;
        cnt_d = '0;
      end else if (emit) begin
        flush_d = flush_pend;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    te_d    = 1'b0;
    unique case (state_q)
      RUN:   if (end_req) state_d = DRAIN;
      DRAIN: if ((cnt_q == '0) || (emit && can_load)) begin
               state_d = WAIT;
               te_d    = 1'b1;
             end
      WAIT:  if (!frame_if.frame_valid || frame_if.frame_ready) state_d = ENDED;
      ENDED: state_d = ENDED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      buf_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      te_q    <= te_d;
    end
  end

  nios2_qsys_oci_dct_frame_reg u_frame_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (emit),
    .data_i     (em_buf),
    .count_i    (em_cnt),
    .drop_i     (drop_st),
    .ovf_clr_i  (overflow_clr),
    .can_load_o (can_load),
    .overflow_o (overflow),
    .fo         (frame_if)
  );

  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_ending    = te_q;
  assign test_has_ended = (state_q == ENDED);
endmodule

// File: tb/tb_nios2_qsys_oci_dct_packer.sv
// Directed bench for the DCT packer: packing, flush, stall/overflow, drain, reset.
module tb_nios2_qsys_oci_dct_packer;
  import nios2_qsys_oci_dct_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              trc_on, code_valid, flush, end_req, overflow_clr;
  logic [CODE_W-1:0] code;
  logic [FRAME_W-1:0] dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              overflow, test_ending, test_has_ended;
  int                checks = 0;
  int                errors = 0;

  nios2_qsys_oci_dct_packer_if fif ();

  nios2_qsys_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trc_on         (trc_on),
    .code_valid     (code_valid),
    .code           (code),
    .flush          (flush),
    .end_req        (end_req),
    .overflow_clr   (overflow_clr),
    .frame_if       (fif),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .overflow       (overflow),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [CODE_W-1:0] c);
    code_valid = 1'b1;
    code       = c;
    step();
    code_valid = 1'b0;
  endtask

  function automatic logic [79:0] all_outs();
    return {6'd0, fif.frame_valid, fif.frame_data, fif.frame_count,
            dct_buffer, dct_count, overflow, test_ending, test_has_ended};
  endfunction

  initial begin
    reset_n = 1'b0; trc_on = 1'b1; code_valid = 1'b0; code = '0;
    flush = 1'b0; end_req = 1'b0; overflow_clr = 1'b0; fif.frame_ready = 1'b1;
    step(); step();
    chk("reset_outputs", all_outs(), 80'd0);
    @(negedge clk) reset_n = 1'b1;

    // Full frame of 1..7,0,1,2
    for (int i = 0; i < 10; i++) begin
      send(CODE_W'((i + 1) % 8));
      if (i == 2) chk("partial_buf", {dct_count, dct_buffer}, {4'd3, 30'o123});
    end
    chk("full_valid", fif.frame_valid, 1);
    chk("full_data",  fif.frame_data, 30'o1234567012);
    chk("full_count", fif.frame_count, 10);
    chk("full_packer_clear", dct_count, 0);
    step();
    chk("full_valid_pulse", fif.frame_valid, 0);

    // Partial frame via flush, then flush on empty packer
    send(3'd5); send(3'd6); send(3'd7);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_frame", {fif.frame_valid, fif.frame_count, fif.frame_data}, {1'b1, 4'd3, 30'o567});
    chk("flush_packer_clear", dct_count, 0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_empty_noemit", fif.frame_valid, 0);

    // Backpressure: 20 codes with frame_ready low
    fif.frame_ready = 1'b0;
    for (int i = 0; i < 20; i++) send(CODE_W'(i % 8));
    chk("stall_held_frame", {fif.frame_valid, fif.frame_data}, {1'b1, 30'o0123456701});
    chk("stall_packer", {dct_count, dct_buffer}, {4'd10, 30'o2345670123});
    chk("stall_overflow", overflow, 1);
    fif.frame_ready = 1'b1; step();
    chk("stall_release_frame", {fif.frame_valid, fif.frame_count, fif.frame_data},
        {1'b1, 4'd10, 30'o2345670123});
    chk("stall_release_packer", dct_count, 0);
    chk("overflow_sticky", overflow, 1);
    overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
    chk("overflow_clr", {overflow, fif.frame_valid}, {1'b0, 1'b0});

    // End-of-test drain
    fif.frame_ready = 1'b0;
    send(3'd1); send(3'd2); send(3'd3); send(3'd4);
    end_req = 1'b1; step(); end_req = 1'b0;
    chk("drain_enter", {test_ending, dct_count}, {1'b0, 4'd4});
    step();
    chk("drain_frame", {fif.frame_valid, fif.frame_count, fif.frame_data}, {1'b1, 4'd4, 30'o1234});
    chk("test_ending_pulse", {test_ending, test_has_ended}, {1'b1, 1'b0});
    step();
    chk("test_ending_drop", {test_ending, test_has_ended}, {1'b0, 1'b0});
    step();
    chk("wait_blocked", test_has_ended, 0);
    fif.frame_ready = 1'b1; step();
    chk("test_has_ended", {test_has_ended, fif.frame_valid}, {1'b1, 1'b0});
    send(3'd5);
    chk("ended_code_ignored", {overflow, dct_count, test_has_ended}, {1'b1, 4'd0, 1'b1});

    // Asynchronous reset mid-frame
    reset_n = 1'b0; step();
    @(negedge clk) reset_n = 1'b1;
    fif.frame_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(CODE_W'(i % 8));
    chk("pre_reset_state", {fif.frame_valid, dct_count}, {1'b1, 4'd6});
    #3 reset_n = 1'b0;
    #1 chk("async_reset", all_outs(), 80'd0);
    @(negedge clk) reset_n = 1'b1;
    fif.frame_ready = 1'b1;
    send(3'd5);
    chk("post_reset_pack", {fif.frame_valid, dct_count, dct_buffer}, {1'b0, 4'd1, 30'o5});

    // trc_on low: codes ignored, flush still works
    trc_on = 1'b0;
    send(3'd7);
    chk("trc_off_hold", {dct_count, dct_buffer}, {4'd1, 30'o5});
    flush = 1'b1; step(); flush = 1'b0;
    chk("trc_off_flush", {fif.frame_valid, fif.frame_count, fif.frame_data}, {1'b1, 4'd1, 30'o5});
    trc_on = 1'b1;

    // flush coincident with the 10th code
    for (int i = 0; i < 9; i++) send(CODE_W'((i + 1) % 8));
    chk("count_nine", dct_count, 9);
    flush = 1'b1; send(3'd3); flush = 1'b0;
    chk("flush_acc_frame", {fif.frame_valid, fif.frame_count, fif.frame_data},
        {1'b1, 4'd10, 30'o1234567013});
    step();
    chk("flush_acc_single", {fif.frame_valid, dct_count}, {1'b0, 4'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
